pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder_if.sv | 26 ++
 rtl/pipelined_adder.sv | 91 +++++++++
 tb/tb_pipelined_adder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result stream bundle for pipelined_adder
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - chunked carry-pipelined adder/subtractor with valid/ready flow control
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_adder_if.slave  bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0] valid_q, valid_d;
  logic              carry_q [STAGES];
  logic              carry_d [STAGES];
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  a_d     [STAGES];
  logic [WIDTH-1:0]  bp_q    [STAGES];
  logic [WIDTH-1:0]  bp_d    [STAGES];
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];

  logic [WIDTH-1:0]  in_a [STAGES];
  logic [WIDTH-1:0]  in_b [STAGES];
  logic [WIDTH-1:0]  in_s [STAGES];
  logic              in_c [STAGES];
  logic              in_v [STAGES];
  logic [CHUNK:0]    part [STAGES];

  logic advance;

  assign advance      = !valid_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance && !rst;

  // Stage 0 sees the raw beat; later stages see the previous stage's registers.
  for (genvar k = 0; k < STAGES; k++) begin : g_src
    if (k == 0) begin : g_first
      assign in_a[k] = bus.a;
      assign in_b[k] = bus.sub ? ~bus.b : bus.b;
      assign in_c[k] = bus.sub | bus.cin;
      assign in_s[k] = '0;
      assign in_v[k] = bus.in_valid && bus.in_ready;
    end else begin : g_next
      assign in_a[k] = a_q[k-1];
      assign in_b[k] = bp_q[k-1];
      assign in_c[k] = carry_q[k-1];
      assign in_s[k] = sum_q[k-1];
      assign in_v[k] = valid_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, in_a[k][k*CHUNK +: CHUNK]}
              + {1'b0, in_b[k][k*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, in_c[k]};
      a_d[k]     = in_a[k];
      bp_d[k]    = in_b[k];
      sum_d[k]   = in_s[k];
      sum_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      carry_d[k] = part[k][CHUNK];
      valid_d[k] = in_v[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        carry_q[k] <= 1'b0;
        a_q[k]     <= '0;
        bp_q[k]    <= '0;
        sum_q[k]   <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        carry_q[k] <= carry_d[k];
        a_q[k]     <= a_d[k];
        bp_q[k]    <= bp_d[k];
        sum_q[k]   <= sum_d[k];
      end
    end
  end

  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  // Carry into the MSB is recovered from the MSB's own sum and operand bits.
  assign bus.ovf       = sum_q[STAGES-1][WIDTH-1] ^ a_q[STAGES-1][WIDTH-1]
                       ^ bp_q[STAGES-1][WIDTH-1] ^ carry_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - self-checking bench for pipelined_adder
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  pipelined_adder_if #(.WIDTH(8)) d8 ();
  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (.clk(clk), .rst(rst), .bus(d8.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] e_sum;
    logic       e_cout;
    logic       e_ovf;
  } vec_t;

  task automatic send_one(input vec_t v, input string tag);
    @(negedge clk);
    d8.in_valid = 1'b1; d8.a = v.a; d8.b = v.b; d8.cin = v.cin; d8.sub = v.sub;
    d8.out_ready = 1'b1;
    #1 check({tag, " in_ready"}, d8.in_ready, 1'b1);
    @(negedge clk);
    d8.in_valid = 1'b0;
    #1 check({tag, " early"}, d8.out_valid, 1'b0);
    @(negedge clk);
    #1;
    check({tag, " out_valid"}, d8.out_valid, 1'b1);
    check({tag, " sum"}, d8.sum, v.e_sum);
    check({tag, " cout"}, d8.cout, v.e_cout);
    check({tag, " ovf"}, d8.ovf, v.e_ovf);
  endtask

  // WIDTH=32 sweep over several stage counts against an arithmetic reference.
  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    int          acc_cyc;
    int          acc_stalls;
  } exp_t;

  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 4 : 8;
    bit sweep_go = 1'b0;
    bit done     = 1'b0;
    pipelined_adder_if #(.WIDTH(32)) ifc ();
    pipelined_adder #(.WIDTH(32), .STAGES(ST)) dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    initial begin
      exp_t        q[$];
      exp_t        e;
      logic [31:0] bp;
      logic        c0;
      logic [32:0] full;
      int          cyc = 0, accepted = 0, stalls = 0;
      ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0; ifc.sub = 1'b0;
      ifc.out_ready = 1'b1;
      wait (sweep_go);
      while ((accepted < 1000 || q.size() > 0) && cyc < 20000) begin
        @(negedge clk);
        ifc.in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
        ifc.a         = $urandom;
        ifc.b         = $urandom;
        ifc.cin       = 1'($urandom);
        ifc.sub       = 1'($urandom);
        ifc.out_ready = (accepted >= 1000) || ($urandom_range(0, 3) != 0);
        #1;
        if (ifc.out_valid) begin
          if (q.size() == 0) begin
            check($sformatf("S%0d spurious out_valid", ST), 1'b1, 1'b0);
          end else begin
            check($sformatf("S%0d sum", ST), ifc.sum, q[0].s);
            check($sformatf("S%0d cout", ST), ifc.cout, q[0].c);
            check($sformatf("S%0d ovf", ST), ifc.ovf, q[0].o);
            if (ifc.out_ready) begin
              check($sformatf("S%0d latency", ST), cyc - q[0].acc_cyc,
                    ST + (stalls - q[0].acc_stalls));
              void'(q.pop_front());
            end
          end
          if (!ifc.out_ready) stalls++;
        end
        if (ifc.in_valid && ifc.in_ready) begin
          bp   = ifc.sub ? ~ifc.b : ifc.b;
          c0   = ifc.sub ? 1'b1 : ifc.cin;
          full = {1'b0, ifc.a} + {1'b0, bp} + {32'd0, c0};
          e.s  = full[31:0];
          e.c  = full[32];
          e.o  = (ifc.a[31] == bp[31]) && (full[31] != ifc.a[31]);
          e.acc_cyc    = cyc;
          e.acc_stalls = stalls;
          q.push_back(e);
          accepted++;
        end
        cyc++;
      end
      check($sformatf("S%0d all beats retired", ST), {accepted == 1000, q.size() == 0}, 2'b11);
      ifc.in_valid = 1'b0;
      done = 1'b1;
    end
  end

  vec_t vecs[10];

  initial begin
    int sent, got, cyc, t;
    vecs[0] = '{8'h03, 8'h05, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h06, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[9] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};

    d8.in_valid = 1'b0; d8.a = '0; d8.b = '0; d8.cin = 1'b0; d8.sub = 1'b0;
    d8.out_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset out_valid", d8.out_valid, 1'b0);
    check("reset sum", d8.sum, 8'h00);
    check("reset cout", d8.cout, 1'b0);
    check("reset ovf", d8.ovf, 1'b0);
    check("reset in_ready low", d8.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("in_ready after release", d8.in_ready, 1'b1);

    for (int i = 0; i < 10; i++) send_one(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back beats with a three-cycle output stall.
    sent = 0; got = 0; cyc = 0;
    while (got < 6 && cyc < 40) begin
      @(negedge clk);
      d8.out_ready = !(cyc >= 3 && cyc <= 5);
      d8.in_valid  = (sent < 6);
      d8.a = 8'(sent); d8.b = 8'(2 * sent); d8.cin = 1'b0; d8.sub = 1'b0;
      #1;
      if (d8.out_valid && !d8.out_ready) check("bp in_ready", d8.in_ready, 1'b0);
      if (d8.out_valid) begin
        check($sformatf("bp sum%0d", got), d8.sum, 8'(3 * got));
        if (d8.out_ready) got++;
      end
      if (d8.in_valid && d8.in_ready) sent++;
      cyc++;
    end
    check("bp delivered", got, 6);

    // Reset with two beats stuck in flight.
    @(negedge clk);
    d8.in_valid = 1'b1; d8.a = 8'h01; d8.b = 8'h01; d8.out_ready = 1'b0;
    @(negedge clk);
    d8.a = 8'h02; d8.b = 8'h02;
    @(negedge clk);
    d8.in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; d8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("flushed %0d", i), d8.out_valid, 1'b0);
      @(negedge clk);
    end
    send_one('{8'h09, 8'h04, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b0}, "post-reset");

    sw[0].sweep_go = 1'b1; sw[1].sweep_go = 1'b1; sw[2].sweep_go = 1'b1;
    t = 0;
    while (!(sw[0].done && sw[1].done && sw[2].done) && t < 70000) begin
      @(negedge clk);
      t++;
    end
    check("sweep finished", {sw[0].done, sw[1].done, sw[2].done}, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
